// File: rtl/raiz_pkg.sv
// Shared types and default sizing for the square-root arbiter slice.
package raiz_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping.
module rr_picker
  import raiz_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    index
);

  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = PW'((int'(ptr) + off) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/raiz_arbiter.sv
// Round-robin arbiter sharing one square-root unit among N_REQ requesters,
// with a WAIT timeout that completes the job with an error flag.
module raiz_arbiter
  import raiz_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [W/2-1:0]     rsp_data,
  output logic [3:0]         rsp_cycles,
  output logic               rsp_err,
  output logic               busy,
  output logic               sq_start,
  output logic [W-1:0]       sq_data,
  input  logic               sq_done,
  input  logic [W/2-1:0]     sq_data_out,
  input  logic [3:0]         sq_cycles
);

  localparam int PW = idx_w(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [CW-1:0] cnt;
  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic [W-1:0]  pick_op;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .index (pick_idx)
  );

  always_comb begin
    pick_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == pick_idx) pick_op = req_data[i*W +: W];
    end
  end

  assign busy = (state != ST_IDLE);

  // ack and sq_start are registered so they line up exactly with RESP / ISSUE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= PW'(N_REQ - 1);
      gnt        <= '0;
      cnt        <= '0;
      ack        <= '0;
      sq_start   <= 1'b0;
      sq_data    <= '0;
      rsp_data   <= '0;
      rsp_cycles <= '0;
      rsp_err    <= 1'b0;
    end else begin
      ack      <= '0;
      sq_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt      <= pick_idx;
            sq_data  <= pick_op;
            sq_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done on the final timeout cycle still counts as a good result.
          if (sq_done) begin
            rsp_data   <= sq_data_out;
            rsp_cycles <= sq_cycles;
            rsp_err    <= 1'b0;
            ack        <= N_REQ'(1) << gnt;
            state      <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_data   <= '0;
            rsp_cycles <= '0;
            rsp_err    <= 1'b1;
            ack        <= N_REQ'(1) << gnt;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          ptr   <= gnt;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
